// File: rtl/calpoc_pkg.sv
// Shared types and constants for the register-bank read path.
// FSM state encoding and the all-released output-enable pattern.
package calpoc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_PRESENT = 2'd2
  } state_e;

  localparam int OE_MAXW = 64;

  // Slice the low NREG bits for a bank of NREG registers.
  localparam logic [OE_MAXW-1:0] OE_OFF = '1;

endpackage

// File: rtl/oe_n_decode.sv
// Index to one-hot active-low output-enable decoder.
// Ports: en_i gates the decode, addr_i register index, oe_n_o enables.
module oe_n_decode #(
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  logic            en_i,
  input  logic [AW-1:0]   addr_i,
  output logic [NREG-1:0] oe_n_o
);

  always_comb begin
    oe_n_o = '1;
    for (int i = 0; i < NREG; i++) begin
      if (en_i && (addr_i == AW'(i))) begin
        oe_n_o[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/reg_bank_reader.sv
// Burst read sequencer for a bank of tri-state nibble registers.
// Ports: CP/MR clock and async reset, cmd_* burst request,
//   oe_n per-register enables, bus_d shared bus, out_* nibble stream,
//   busy high outside IDLE.
module reg_bank_reader
  import calpoc_pkg::*;
#(
  parameter int NREG   = 8,
  parameter int SETTLE = 1,
  parameter int LW     = 4,
  localparam int AW    = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic            CP,
  input  logic            MR,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [LW-1:0]   cmd_len,
  output logic [NREG-1:0] oe_n,
  input  logic [3:0]      bus_d,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_data,
  output logic            out_last,
  output logic            busy
);

  localparam logic [NREG-1:0] OFF = OE_OFF[NREG-1:0];
  localparam logic [3:0] CNT_END = 4'(SETTLE - 1);

  state_e          state_q;
  logic [AW-1:0]   addr_q;
  logic [LW-1:0]   rem_q;
  logic [3:0]      cnt_q;
  logic [NREG-1:0] oe_n_q;
  logic            out_valid_q;
  logic [3:0]      out_data_q;
  logic            out_last_q;

  logic [AW-1:0]   cmd_addr_m;
  logic [AW-1:0]   addr_d;
  logic [AW-1:0]   dec_addr;
  logic            dec_en;
  logic [NREG-1:0] dec_oe;
  logic            hs;
  logic            rem_zero;

  // cmd_addr is below 2^AW < 2*NREG, so one subtraction is a full modulo.
  always_comb begin
    cmd_addr_m = cmd_addr;
    if ({1'b0, cmd_addr} >= (AW+1)'(NREG)) begin
      cmd_addr_m = cmd_addr - AW'(NREG);
    end
  end

  assign addr_d   = (addr_q == AW'(NREG - 1)) ? '0 : addr_q + AW'(1);
  assign hs       = out_valid_q & out_ready;
  assign rem_zero = (rem_q == '0);

  // Decode the index of whichever register the next DRIVE selects.
  always_comb begin
    dec_addr = addr_d;
    dec_en   = 1'b0;
    if (state_q == ST_IDLE) begin
      dec_addr = cmd_addr_m;
      dec_en   = cmd_valid;
    end else if (state_q == ST_PRESENT) begin
      dec_en = hs & ~rem_zero;
    end
  end

  oe_n_decode #(
    .NREG (NREG),
    .AW   (AW)
  ) u_dec (
    .en_i   (dec_en),
    .addr_i (dec_addr),
    .oe_n_o (dec_oe)
  );

  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      oe_n_q      <= OFF;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_q  <= cmd_addr_m;
            rem_q   <= cmd_len;
            cnt_q   <= '0;
            oe_n_q  <= dec_oe;
            state_q <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == CNT_END) begin
            out_data_q  <= bus_d;
            out_last_q  <= rem_zero;
            out_valid_q <= 1'b1;
            oe_n_q      <= OFF;
            state_q     <= ST_PRESENT;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_PRESENT: begin
          if (hs) begin
            out_valid_q <= 1'b0;
            if (rem_zero) begin
              state_q <= ST_IDLE;
            end else begin
              rem_q   <= rem_q - LW'(1);
              addr_q  <= addr_d;
              cnt_q   <= '0;
              oe_n_q  <= dec_oe;
              state_q <= ST_DRIVE;
            end
          end
        end
        default: begin
          oe_n_q      <= OFF;
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  // Held low through reset so no command is taken until MR falls.
  assign cmd_ready = (state_q == ST_IDLE) & ~MR;
  assign busy      = (state_q != ST_IDLE);
  assign oe_n      = oe_n_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_reg_bank_reader.sv
// Self-checking bench for reg_bank_reader.
// Scoreboarded nibble stream, vector table, directed corner sequences.
module tb_reg_bank_reader;

  logic       CP;
  logic       MR;
  logic [3:0] mem [8];

  logic       cv, cr, ov, ordy, ol, bsy;
  logic [2:0] ca;
  logic [3:0] cl, od, bus1;
  logic [7:0] oe;

  logic       cv3, cr3, ov3, r3, ol3, bsy3;
  logic [2:0] ca3;
  logic [3:0] cl3, od3, bus3;
  logic [7:0] oe3;

  int checks = 0;
  int errors = 0;
  int obs_n  = 0;
  logic [3:0] first_d;

  typedef struct {
    logic [3:0] d;
    logic       l;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [2:0] addr;
    logic [3:0] len;
    logic [3:0] exp_first;
    int         exp_n;
    int         exp_cyc;
  } vec_t;

  reg_bank_reader #(.NREG(8), .SETTLE(1), .LW(4)) u1 (
    .CP(CP), .MR(MR),
    .cmd_valid(cv), .cmd_ready(cr),
    .cmd_addr(ca), .cmd_len(cl),
    .oe_n(oe), .bus_d(bus1),
    .out_valid(ov), .out_ready(ordy),
    .out_data(od), .out_last(ol),
    .busy(bsy)
  );

  reg_bank_reader #(.NREG(8), .SETTLE(3), .LW(4)) u3 (
    .CP(CP), .MR(MR),
    .cmd_valid(cv3), .cmd_ready(cr3),
    .cmd_addr(ca3), .cmd_len(cl3),
    .oe_n(oe3), .bus_d(bus3),
    .out_valid(ov3), .out_ready(r3),
    .out_data(od3), .out_last(ol3),
    .busy(bsy3)
  );

  initial begin
    CP = 1'b0;
    forever #5 CP = ~CP;
  end

  always_comb begin
    bus1 = 4'h0;
    bus3 = 4'h0;
    for (int i = 0; i < 8; i++) begin
      if (!oe[i])  bus1 = mem[i];
      if (!oe3[i]) bus3 = mem[i];
    end
  end

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               n, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [2:0] a,
                          input logic [3:0] l);
    exp_t e;
    for (int j = 0; j <= int'(l); j++) begin
      e.d = mem[(int'(a) + j) % 8];
      e.l = (j == int'(l));
      sb.push_back(e);
    end
  endtask

  always @(negedge CP) begin
    if (!MR && ov && ordy) begin
      if (sb.size() == 0) begin
        chk("sb underflow", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("nibble data", od, e.d);
        chk("nibble last", ol, e.l);
      end
      if (obs_n == 0) first_d = od;
      obs_n++;
    end
  end

  always @(negedge CP) begin
    if (!MR) begin
      chk("oe excl u1", ($countones(~oe) > 1), 0);
      chk("oe off in present u1", (ov && oe != 8'hFF), 0);
      chk("oe excl u3", ($countones(~oe3) > 1), 0);
      chk("oe off in present u3", (ov3 && oe3 != 8'hFF), 0);
    end
  end

  task automatic issue_cmd(input logic [2:0] a,
                           input logic [3:0] l);
    @(posedge CP); #1;
    chk("cmd_ready idle", cr, 1);
    cv = 1'b1;
    ca = a;
    cl = l;
    push_exp(a, l);
    @(posedge CP); #1;
    cv = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input bit rnd,
                           output int cyc);
    bit done;
    cyc  = 0;
    done = 0;
    while (!done) begin
      @(negedge CP);
      if (!bsy) begin
        done = 1;
      end else begin
        cyc++;
        if (cyc > maxc) begin
          chk("idle timeout", cyc, maxc);
          done = 1;
        end else begin
          @(posedge CP); #1;
          if (rnd) ordy = 1'($urandom_range(0, 1));
        end
      end
    end
  endtask

  vec_t vt[5];
  int   cyc;

  initial begin
    vt[0] = '{3'd6, 4'd3,  4'h7, 4,  8};
    vt[1] = '{3'd0, 4'd0,  4'h1, 1,  2};
    vt[2] = '{3'd7, 4'd15, 4'h8, 16, 32};
    vt[3] = '{3'd3, 4'd1,  4'h4, 2,  4};
    vt[4] = '{3'd5, 4'd7,  4'h6, 8,  16};
    for (int i = 0; i < 8; i++) mem[i] = 4'(i + 1);

    MR = 1'b1;
    cv = 0; ca = 0; cl = 0; ordy = 1;
    cv3 = 0; ca3 = 0; cl3 = 0; r3 = 0;
    #2;
    chk("rst oe_n", oe, 8'hFF);
    chk("rst out_valid", ov, 0);
    chk("rst out_data", od, 0);
    chk("rst out_last", ol, 0);
    chk("rst busy", bsy, 0);
    chk("rst cmd_ready", cr, 0);
    @(posedge CP); #1;
    MR = 1'b0;
    @(negedge CP);
    chk("cmd_ready after rst", cr, 1);

    // single read of register 3
    mem[3] = 4'hA;
    @(posedge CP); #1;
    cv = 1; ca = 3'd3; cl = 4'd0;
    push_exp(3'd3, 4'd0);
    @(posedge CP); #1;
    cv = 0;
    @(negedge CP);
    chk("single oe_n", oe, 8'hF7);
    chk("single valid early", ov, 0);
    chk("single busy", bsy, 1);
    chk("single cmd_ready busy", cr, 0);
    @(posedge CP); #1;
    @(negedge CP);
    chk("single valid", ov, 1);
    chk("single data", od, 4'hA);
    chk("single last", ol, 1);
    chk("single oe released", oe, 8'hFF);
    @(posedge CP); #1;
    @(negedge CP);
    chk("single idle busy", bsy, 0);
    chk("single idle valid", ov, 0);
    chk("single idle ready", cr, 1);
    mem[3] = 4'h4;

    // table of bursts, out_ready held high
    for (int v = 0; v < 5; v++) begin
      obs_n = 0;
      issue_cmd(vt[v].addr, vt[v].len);
      wait_idle(100, 0, cyc);
      chk("vec cycles", cyc, vt[v].exp_cyc);
      chk("vec count", obs_n, vt[v].exp_n);
      chk("vec first", first_d, vt[v].exp_first);
      chk("vec sb empty", sb.size(), 0);
    end

    // busy rejection with cmd_valid held high
    obs_n = 0;
    @(posedge CP); #1;
    cv = 1; ca = 3'd1; cl = 4'd2;
    push_exp(3'd1, 4'd2);
    @(posedge CP); #1;
    ca = 3'd5; cl = 4'd0;
    cyc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CP);
      if (!bsy) break;
      cyc++;
      chk("reject cmd_ready", cr, 0);
      @(posedge CP); #1;
    end
    chk("reject burst cycles", cyc, 6);
    chk("reject nibbles", obs_n, 3);
    chk("reject idle ready", cr, 1);
    push_exp(3'd5, 4'd0);
    @(posedge CP); #1;
    cv = 0;
    @(negedge CP);
    chk("second accepted", bsy, 1);
    chk("second oe_n", oe, 8'hDF);
    wait_idle(50, 0, cyc);
    chk("reject total", obs_n, 4);
    chk("reject sb empty", sb.size(), 0);

    // async reset while register 2 is driving
    @(posedge CP); #1;
    cv = 1; ca = 3'd2; cl = 4'd3;
    push_exp(3'd2, 4'd3);
    @(posedge CP); #1;
    cv = 0;
    chk("mid oe_n", oe, 8'hFB);
    #1 MR = 1'b1;
    #1;
    chk("mid rst oe_n", oe, 8'hFF);
    chk("mid rst valid", ov, 0);
    chk("mid rst busy", bsy, 0);
    #1 MR = 1'b0;
    sb.delete();
    @(negedge CP);
    chk("mid rst ready", cr, 1);
    chk("mid rst idle", bsy, 0);
    @(posedge CP); #1;
    @(negedge CP);
    chk("mid rst no pulse", ov, 0);

    // backpressure on the SETTLE=3 instance
    @(posedge CP); #1;
    cv3 = 1; ca3 = 3'd4; cl3 = 4'd1;
    @(posedge CP); #1;
    cv3 = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CP);
      chk("bp settle oe", oe3, 8'hEF);
      chk("bp settle valid", ov3, 0);
      @(posedge CP); #1;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge CP);
      chk("bp hold valid", ov3, 1);
      chk("bp hold data", od3, 4'h5);
      chk("bp hold last", ol3, 0);
      chk("bp hold oe", oe3, 8'hFF);
      @(posedge CP); #1;
    end
    r3 = 1;
    @(negedge CP);
    chk("bp hs valid", ov3, 1);
    chk("bp hs data", od3, 4'h5);
    @(posedge CP); #1;
    r3 = 0;
    @(negedge CP);
    chk("bp next valid", ov3, 0);
    chk("bp next oe", oe3, 8'hDF);
    for (int i = 0; i < 2; i++) begin
      @(posedge CP); #1;
      @(negedge CP);
      chk("bp next settle", oe3, 8'hDF);
    end
    @(posedge CP); #1;
    @(negedge CP);
    chk("bp 2nd valid", ov3, 1);
    chk("bp 2nd data", od3, 4'h6);
    chk("bp 2nd last", ol3, 1);
    @(posedge CP); #1;
    r3 = 1;
    @(posedge CP); #1;
    r3 = 0;
    @(negedge CP);
    chk("bp idle", bsy3, 0);

    // random run with random backpressure
    for (int i = 0; i < 8; i++) mem[i] = 4'($urandom);
    obs_n = 0;
    for (int n = 0; n < 1000; n++) begin
      issue_cmd(3'($urandom), 4'($urandom_range(0, 3)));
      wait_idle(200, 1, cyc);
    end
    ordy = 1;
    chk("random sb empty", sb.size(), 0);
    chk("random nibbles >= cmds", (obs_n >= 1000), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
